// File: rtl/game_state_sequencer.sv
// Game flow sequencer: converts authentication and level result pulses into
// the LCD display state code, tracking level and authentication attempts.
// Message states are held for HOLD_CYCLES before advancing automatically.
module game_state_sequencer #(
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned MAX_TRIES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       auth_ok,
    input  logic       auth_fail,
    input  logic       lvl_pass,
    input  logic       lvl_fail,
    input  logic       start,
    output logic [7:0] state,
    output logic       state_change,
    output logic [1:0] level,
    output logic [1:0] tries,
    output logic       game_active
);

    localparam logic [26:0] HOLD_LAST = 27'(HOLD_CYCLES - 1);
    localparam logic [1:0]  TRIES_MAX = 2'(MAX_TRIES);

    typedef enum logic [7:0] {
        ST_AUTH      = 8'h00,
        ST_AUTH_OK   = 8'h01,
        ST_AUTH_FAIL = 8'h02,
        ST_PLAY      = 8'h10,
        ST_L1_PASS   = 8'h11,
        ST_L1_FAIL   = 8'h12,
        ST_L2_PASS   = 8'h13,
        ST_L2_FAIL   = 8'h14,
        ST_L3_FAIL   = 8'h16,
        ST_WIN       = 8'h20,
        ST_WIN_DONE  = 8'h21,
        ST_LOSE      = 8'h30,
        ST_LOSE_DONE = 8'h31
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  level_q, level_d;
    logic [1:0]  tries_q, tries_d;
    logic [26:0] cnt_q, cnt_d;
    logic        state_change_q, state_change_d;
    logic        game_active_q, game_active_d;
    logic        hold_done;

    assign hold_done = (cnt_q == HOLD_LAST);

    // Register all state and outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_AUTH;
            level_q        <= 2'd0;
            tries_q        <= 2'd0;
            cnt_q          <= 27'd0;
            state_change_q <= 1'b0;
            game_active_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_q        <= level_d;
            tries_q        <= tries_d;
            cnt_q          <= cnt_d;
            state_change_q <= state_change_d;
            game_active_q  <= game_active_d;
        end
    end

    // Next-state, level/tries bookkeeping and hold counter.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        tries_d = tries_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_AUTH: begin
                // A rejected credential takes priority over an accepted one.
                if (auth_fail) begin
                    state_d = ST_AUTH_FAIL;
                    tries_d = (tries_q == TRIES_MAX) ? tries_q : tries_q + 2'd1;
                end else if (auth_ok) begin
                    state_d = ST_AUTH_OK;
                end
            end
            ST_PLAY: begin
                if (lvl_fail) begin
                    case (level_q)
                        2'd1:    state_d = ST_L1_FAIL;
                        2'd2:    state_d = ST_L2_FAIL;
                        default: state_d = ST_L3_FAIL;
                    endcase
                end else if (lvl_pass) begin
                    case (level_q)
                        2'd1:    state_d = ST_L1_PASS;
                        2'd2:    state_d = ST_L2_PASS;
                        default: state_d = ST_WIN;
                    endcase
                end
            end
            ST_AUTH_OK, ST_AUTH_FAIL, ST_L1_PASS, ST_L2_PASS,
            ST_L1_FAIL, ST_L2_FAIL, ST_L3_FAIL, ST_WIN, ST_LOSE: begin
                if (!hold_done) begin
                    cnt_d = cnt_q + 27'd1;
                end else begin
                    case (state_q)
                        ST_AUTH_OK: begin
                            state_d = ST_PLAY;
                            level_d = 2'd1;
                        end
                        ST_AUTH_FAIL: state_d = (tries_q == TRIES_MAX) ? ST_LOSE : ST_AUTH;
                        ST_L1_PASS, ST_L2_PASS: begin
                            state_d = ST_PLAY;
                            level_d = level_q + 2'd1;
                        end
                        ST_WIN:  state_d = ST_WIN_DONE;
                        default: state_d = ST_LOSE_DONE;
                    endcase
                    if (state_q == ST_L1_FAIL || state_q == ST_L2_FAIL ||
                        state_q == ST_L3_FAIL) begin
                        state_d = ST_LOSE;
                    end
                end
            end
            ST_WIN_DONE, ST_LOSE_DONE: begin
                if (start) begin
                    state_d = ST_AUTH;
                    level_d = 2'd0;
                    tries_d = 2'd0;
                end
            end
            default: begin
                // Unlisted encoding: recover to a clean authentication state.
                state_d = ST_AUTH;
                level_d = 2'd0;
                tries_d = 2'd0;
            end
        endcase

        // Every state entry restarts the hold count.
        if (state_d != state_q) begin
            cnt_d = 27'd0;
        end
    end

    // Registered flags derived from the upcoming state.
    always_comb begin
        state_change_d = (state_d != state_q);
        game_active_d  = (state_d == ST_PLAY);
    end

    assign state        = state_q;
    assign state_change = state_change_q;
    assign level        = level_q;
    assign tries        = tries_q;
    assign game_active  = game_active_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Testbench for game_state_sequencer: directed scenarios followed by random
// pulses, checked every cycle against a behavioural model of the game rules.
module tb_game_state_sequencer;

    localparam int HOLD = 4;
    localparam int MAXT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       auth_ok = 1'b0, auth_fail = 1'b0, lvl_pass = 1'b0;
    logic       lvl_fail = 1'b0, start = 1'b0;
    logic [7:0] state;
    logic       state_change;
    logic [1:0] level, tries;
    logic       game_active;

    int total = 0;
    int bad   = 0;
    int chg_cnt = 0;

    // Model of the game: display code, level, tries, cycles left on screen.
    int m_state, m_level, m_tries, m_left;
    bit m_chg;

    game_state_sequencer #(.HOLD_CYCLES(HOLD), .MAX_TRIES(MAXT)) dut (
        .clk(clk), .reset(reset),
        .auth_ok(auth_ok), .auth_fail(auth_fail),
        .lvl_pass(lvl_pass), .lvl_fail(lvl_fail), .start(start),
        .state(state), .state_change(state_change),
        .level(level), .tries(tries), .game_active(game_active)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic bit is_msg(int s);
        return s == 'h01 || s == 'h02 || s == 'h11 || s == 'h12 || s == 'h13 ||
               s == 'h14 || s == 'h16 || s == 'h20 || s == 'h30;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_tries = 0; m_left = 0; m_chg = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int nxt;
        if (!reset) begin
            model_reset();
            return;
        end
        nxt = m_state;
        if (is_msg(m_state)) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                case (m_state)
                    'h01: begin nxt = 'h10; m_level = 1; end
                    'h02: nxt = (m_tries == MAXT) ? 'h30 : 'h00;
                    'h11, 'h13: begin nxt = 'h10; m_level++; end
                    'h20: nxt = 'h21;
                    'h30: nxt = 'h31;
                    default: nxt = 'h30;
                endcase
            end
        end else if (m_state == 'h00) begin
            if (auth_fail) begin nxt = 'h02; m_tries++; end
            else if (auth_ok) nxt = 'h01;
        end else if (m_state == 'h10) begin
            if (lvl_fail)      nxt = (m_level == 1) ? 'h12 : (m_level == 2) ? 'h14 : 'h16;
            else if (lvl_pass) nxt = (m_level == 1) ? 'h11 : (m_level == 2) ? 'h13 : 'h20;
        end else if (start) begin
            nxt = 'h00; m_level = 0; m_tries = 0;
        end
        m_chg = (nxt != m_state);
        if (m_chg && is_msg(nxt)) m_left = HOLD;
        m_state = nxt;
    endtask

    task automatic check(string tag);
        total++;
        assert (state === 8'(m_state)) else begin
            bad++; $error("FAIL %s state got=%02h want=%02h", tag, state, 8'(m_state));
        end
        total++;
        assert (state_change === m_chg) else begin
            bad++; $error("FAIL %s state_change got=%0b want=%0b", tag, state_change, m_chg);
        end
        total++;
        assert (level === 2'(m_level)) else begin
            bad++; $error("FAIL %s level got=%0d want=%0d", tag, level, m_level);
        end
        total++;
        assert (tries === 2'(m_tries)) else begin
            bad++; $error("FAIL %s tries got=%0d want=%0d", tag, tries, m_tries);
        end
        total++;
        assert (game_active === (m_state == 'h10)) else begin
            bad++; $error("FAIL %s game_active got=%0b want=%0b", tag, game_active, m_state == 'h10);
        end
    endtask

    // Explicit check of one DUT value against a constant from the scenario.
    task automatic expect_val(string tag, int got, int want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One clock cycle with the given inputs, then model update and check.
    task automatic step(string tag, bit ao, bit af, bit lp, bit lf, bit st);
        auth_ok = ao; auth_fail = af; lvl_pass = lp; lvl_fail = lf; start = st;
        @(posedge clk);
        model_step();
        #1;
        check(tag);
        if (state_change === 1'b1) chg_cnt++;
        if (m_chg) $display("t=%0t %s: state=%02h level=%0d tries=%0d", $time, tag, state, level, tries);
        auth_ok = 0; auth_fail = 0; lvl_pass = 0; lvl_fail = 0; start = 0;
    endtask

    task automatic idle(string tag, int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0);
    endtask

    // Idle until the DUT shows the target code, bounded by a cycle budget.
    task automatic wait_for(string tag, int target, int budget);
        int n = 0;
        while (state !== 8'(target) && n < budget) begin
            step(tag, 0, 0, 0, 0, 0);
            n++;
        end
        expect_val(tag, int'(state), target);
    endtask

    initial begin
        model_reset();
        #12;
        check("reset");
        expect_val("reset_state", int'(state), 'h00);
        reset = 1'b1;
        idle("post_reset", 3);

        // Ignored: level pulse while authenticating.
        step("ign_lvl_pass", 0, 0, 1, 0, 0);
        expect_val("ign_lvl_pass_chg", int'(state_change), 0);

        // Happy path through all three levels.
        chg_cnt = 0;
        step("happy_auth", 1, 0, 0, 0, 0);
        wait_for("happy_l1", 'h10, 10);
        step("ign_auth_ok", 1, 0, 0, 0, 0);
        step("ign_start", 0, 0, 0, 0, 1);
        expect_val("ign_start_state", int'(state), 'h10);
        step("happy_p1", 0, 0, 1, 0, 0);
        wait_for("happy_l2", 'h10, 10);
        step("happy_p2", 0, 0, 1, 0, 0);
        wait_for("happy_l3", 'h10, 10);
        expect_val("happy_level3", int'(level), 3);
        step("happy_p3", 0, 0, 1, 0, 0);
        wait_for("happy_win", 'h21, 10);
        idle("happy_hold", 3);
        expect_val("happy_changes", chg_cnt, 8);
        step("happy_restart", 0, 0, 0, 0, 1);

        // Lockout after three rejected credentials.
        for (int k = 0; k < 3; k++) begin
            step("lock_fail", 0, 1, 0, 0, 0);
            if (k < 2) wait_for("lock_back", 'h00, 10);
        end
        wait_for("lock_end", 'h31, 12);
        expect_val("lock_tries", int'(tries), 3);
        step("lock_restart", 0, 0, 0, 0, 1);
        expect_val("lock_restart_tries", int'(tries), 0);

        // Level 2 failure, then restart.
        step("l2f_auth", 1, 0, 0, 0, 0);
        wait_for("l2f_l1", 'h10, 10);
        step("l2f_p1", 0, 0, 1, 0, 0);
        wait_for("l2f_l2", 'h10, 10);
        step("l2f_fail", 0, 0, 0, 1, 0);
        expect_val("l2f_state", int'(state), 'h14);
        wait_for("l2f_end", 'h31, 12);
        idle("l2f_hold", 4);
        step("l2f_start", 0, 0, 0, 0, 1);
        expect_val("l2f_level", int'(level), 0);

        // Simultaneous events: failure wins in both pairs.
        step("sim_auth", 1, 0, 0, 0, 0);
        wait_for("sim_l1", 'h10, 10);
        step("sim_lvl_both", 0, 0, 1, 1, 0);
        expect_val("sim_lvl_state", int'(state), 'h12);
        wait_for("sim_end", 'h31, 12);
        step("sim_start", 0, 0, 0, 0, 1);
        step("sim_auth_both", 1, 1, 0, 0, 0);
        expect_val("sim_auth_state", int'(state), 'h02);
        expect_val("sim_auth_tries", int'(tries), 1);
        wait_for("sim_back", 'h00, 10);
        step("b2b_fail", 0, 1, 0, 0, 0);
        expect_val("b2b_state", int'(state), 'h02);
        wait_for("b2b_back", 'h00, 10);
        step("b2b_ok", 1, 0, 0, 0, 0);

        // Reset asserted during the second cycle of 0x13.
        wait_for("rst_l1", 'h10, 10);
        step("rst_p1", 0, 0, 1, 0, 0);
        wait_for("rst_l2", 'h10, 10);
        step("rst_p2", 0, 0, 1, 0, 0);
        step("rst_hold", 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_async");
        step("rst_low", 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        idle("rst_after", 6);
        expect_val("rst_stay", int'(state), 'h00);
        step("rst_auth", 1, 0, 0, 0, 0);

        // Random pulses against the model.
        for (int i = 0; i < 800; i++) begin
            step("rand",
                 ($urandom_range(7) == 0), ($urandom_range(9) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(11) == 0),
                 ($urandom_range(9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
